// File: rtl/key_cfg_ctrl.sv
// key_cfg_ctrl -- keypad command controller for the edge-detection pipeline.
//
// Decodes single-cycle key strobes from the 4x4 keypad scanner into a Sobel
// threshold and a bypass flag. The controller supports:
//   - decimal entry of up to three digits
//   - step adjust (+/- THR_STEP, saturating)
//   - bypass toggle
//   - restore-default
// Each new configuration is offered to the datapath with a valid/ready handshake.
//
// Key map: 0-9 digit, 10 enter, 11 cancel, 12 toggle bypass, 13 +STEP,
//          14 -STEP, 15 restore THR_DEF.
//
// Optional feature: define ENTRY_TIMEOUT_EN to abandon an open decimal entry
// after TIMEOUT_CYC idle cycles. When the macro is undefined, no counter is built.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_num    in   [3:0] key code, valid while key_vld=1
//   key_vld    in   single-cycle key-press strobe
//   cfg_rdy    in   datapath accepts cfg_thr/cfg_bypass
//   cfg_vld    out  new configuration pending
//   cfg_thr    out  [7:0] Sobel magnitude threshold
//   cfg_bypass out  1 = datapath passes raw pixels
//   entry_val  out  [9:0] digits accumulated so far (7-seg display)
//   entry_busy out  1 while a decimal entry is open
//   key_err    out  one-cycle pulse when a key is rejected
module key_cfg_ctrl #(
    parameter logic [7:0]  THR_DEF     = 8'd100,
    parameter logic [7:0]  THR_STEP    = 8'd8,
    parameter logic [26:0] TIMEOUT_CYC = 27'd125_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_num,
    input  logic       key_vld,
    input  logic       cfg_rdy,
    output logic       cfg_vld,
    output logic [7:0] cfg_thr,
    output logic       cfg_bypass,
    output logic [9:0] entry_val,
    output logic       entry_busy,
    output logic       key_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] thr_q, thr_d;
    logic       byp_q, byp_d;
    logic [9:0] entry_q, entry_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       vld_q, busy_q;
    logic [8:0] thr_inc;

    // One extra bit catches the carry used for saturation at 255.
    assign thr_inc = {1'b0, thr_q} + {1'b0, THR_STEP};

`ifdef ENTRY_TIMEOUT_EN
    logic [26:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        byp_d   = byp_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        tmo_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (key_vld) begin
                    if (key_num <= 4'd9) begin
                        state_d = ST_ENTRY;
                        entry_d = {6'd0, key_num};
                        cnt_d   = 2'd1;
                    end else begin
                        case (key_num)
                            4'd12: begin
                                byp_d   = ~byp_q;
                                state_d = ST_COMMIT;
                            end
                            4'd13: begin
                                thr_d   = thr_inc[8] ? 8'd255 : thr_inc[7:0];
                                state_d = ST_COMMIT;
                            end
                            4'd14: begin
                                thr_d   = (thr_q < THR_STEP) ? 8'd0 : thr_q - THR_STEP;
                                state_d = ST_COMMIT;
                            end
                            4'd15: begin
                                thr_d   = THR_DEF;
                                state_d = ST_COMMIT;
                            end
                            default: ; // enter/cancel have no meaning here
                        endcase
                    end
                end
            end
            ST_ENTRY: begin
`ifdef ENTRY_TIMEOUT_EN
                // Counts idle cycles; an accepted key below clears it.
                tmo_d = tmo_q + 27'd1;
                if (tmo_q == TIMEOUT_CYC - 27'd1) begin
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end
`endif
                if (key_vld) begin
                    if (key_num <= 4'd9) begin
                        if (cnt_q < 2'd3) begin
                            // Restore state in case the timeout branch fired this cycle.
                            state_d = ST_ENTRY;
                            err_d   = 1'b0;
                            entry_d = (entry_q * 10'd10) + {6'd0, key_num};
                            cnt_d   = cnt_q + 2'd1;
`ifdef ENTRY_TIMEOUT_EN
                            tmo_d   = '0;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_num == 4'd10) begin
                        state_d = ST_COMMIT;
                        err_d   = 1'b0;
                        // Clamp to the 8-bit threshold range only at commit.
                        thr_d   = (entry_q > 10'd255) ? 8'd255 : entry_q[7:0];
                        entry_d = '0;
                        cnt_d   = '0;
`ifdef ENTRY_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else if (key_num == 4'd11) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b0;
                        entry_d = '0;
                        cnt_d   = '0;
`ifdef ENTRY_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                // thr/bypass stay frozen; any key is rejected, even on the handshake edge.
                if (key_vld) err_d = 1'b1;
                if (cfg_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            thr_q   <= THR_DEF;
            byp_q   <= 1'b0;
            entry_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            byp_q   <= byp_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vld_q   <= (state_d == ST_COMMIT);
            busy_q  <= (state_d == ST_ENTRY);
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`endif

    assign cfg_vld    = vld_q;
    assign cfg_thr    = thr_q;
    assign cfg_bypass = byp_q;
    assign entry_val  = entry_q;
    assign entry_busy = busy_q;
    assign key_err    = err_q;

endmodule

// File: tb/tb_key_cfg_ctrl.sv
module tb_key_cfg_ctrl;

    localparam int THR_DEF  = 100;
    localparam int THR_STEP = 8;
`ifdef ENTRY_TIMEOUT_EN
    localparam int TCYC = 16;
`else
    localparam int TCYC = 125_000_000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_num = '0;
    logic       key_vld = 1'b0;
    logic       cfg_rdy = 1'b0;
    logic       cfg_vld;
    logic [7:0] cfg_thr;
    logic       cfg_bypass;
    logic [9:0] entry_val;
    logic       entry_busy;
    logic       key_err;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0 = idle, 1 = typing digits, 2 = awaiting handshake.
    int m_mode, m_thr, m_byp, m_entry, m_ndig, m_err, m_idle;

    always #5 clk = ~clk;

    key_cfg_ctrl #(
        .THR_DEF    (8'(THR_DEF)),
        .THR_STEP   (8'(THR_STEP)),
        .TIMEOUT_CYC(27'(TCYC))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_num   (key_num),
        .key_vld   (key_vld),
        .cfg_rdy   (cfg_rdy),
        .cfg_vld   (cfg_vld),
        .cfg_thr   (cfg_thr),
        .cfg_bypass(cfg_bypass),
        .entry_val (entry_val),
        .entry_busy(entry_busy),
        .key_err   (key_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_thr = THR_DEF; m_byp = 0; m_entry = 0;
        m_ndig = 0; m_err = 0; m_idle = 0;
    endtask

    task automatic model_step(input int v, input int k, input int r);
        bit accepted;
        m_err = 0;
        accepted = 0;
        if (m_mode == 2) begin
            if (v != 0) m_err = 1;
            if (r != 0) m_mode = 0;
        end else if (m_mode == 0) begin
            if (v != 0) begin
                if (k <= 9) begin
                    m_mode = 1; m_entry = k; m_ndig = 1; m_idle = 0;
                end else if (k == 12) begin
                    m_byp = 1 - m_byp; m_mode = 2;
                end else if (k == 13) begin
                    m_thr = (m_thr + THR_STEP > 255) ? 255 : m_thr + THR_STEP; m_mode = 2;
                end else if (k == 14) begin
                    m_thr = (m_thr - THR_STEP < 0) ? 0 : m_thr - THR_STEP; m_mode = 2;
                end else if (k == 15) begin
                    m_thr = THR_DEF; m_mode = 2;
                end
            end
        end else begin
            if (v != 0) begin
                if (k <= 9) begin
                    if (m_ndig < 3) begin
                        m_entry = m_entry * 10 + k; m_ndig++; accepted = 1;
                    end else m_err = 1;
                end else if (k == 10) begin
                    m_thr = (m_entry > 255) ? 255 : m_entry;
                    m_entry = 0; m_ndig = 0; m_mode = 2; accepted = 1;
                end else if (k == 11) begin
                    m_entry = 0; m_ndig = 0; m_mode = 0; accepted = 1;
                end else m_err = 1;
            end
`ifdef ENTRY_TIMEOUT_EN
            if (accepted) m_idle = 0;
            else if (m_idle == TCYC - 1) begin
                m_mode = 0; m_entry = 0; m_ndig = 0; m_err = 1; m_idle = 0;
            end else m_idle++;
`endif
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".vld"},   32'(cfg_vld),    32'(m_mode == 2));
        chk({tag, ".thr"},   32'(cfg_thr),    32'(m_thr));
        chk({tag, ".byp"},   32'(cfg_bypass), 32'(m_byp));
        chk({tag, ".entry"}, 32'(entry_val),  32'(m_entry));
        chk({tag, ".busy"},  32'(entry_busy), 32'(m_mode == 1));
        chk({tag, ".err"},   32'(key_err),    32'(m_err));
    endtask

    // Inputs are applied at the negedge, the DUT samples them at the posedge,
    // and outputs are checked at the following negedge.
    task automatic cycle(input int v, input int k, input int r, input string tag);
        key_vld = 1'(v);
        key_num = 4'(k);
        cfg_rdy = 1'(r);
        @(posedge clk);
        model_step(v, k, r);
        @(negedge clk);
        key_vld = 1'b0;
        compare_all(tag);
        $display("%s: vld=%0b key=%0d rdy=%0b -> cfg_vld=%0b thr=%0d byp=%0b entry=%0d busy=%0b err=%0b",
                 tag, v[0], k, r[0], cfg_vld, cfg_thr, cfg_bypass, entry_val, entry_busy, key_err);
    endtask

    task automatic press(input int k, input int r, input string tag);
        cycle(1, k, r, tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;
        cycle(0, 0, 0, "post_reset");

        // 1: decimal entry 128
        press(1, 1, "t1_k1");
        press(2, 1, "t1_k2");
        chk("t1_entry12", 32'(entry_val), 32'd12);
        press(8, 1, "t1_k8");
        press(10, 1, "t1_enter");
        chk("t1_thr", 32'(cfg_thr), 32'd128);
        chk("t1_vld", 32'(cfg_vld), 32'd1);
        cycle(0, 0, 1, "t1_hs");
        chk("t1_vld_clr", 32'(cfg_vld), 32'd0);

        // 2: fourth digit rejected, 999 clamps to 255
        press(9, 1, "t2_k9a");
        press(9, 1, "t2_k9b");
        press(9, 1, "t2_k9c");
        press(9, 1, "t2_k9d");
        chk("t2_err4", 32'(key_err), 32'd1);
        chk("t2_entry", 32'(entry_val), 32'd999);
        press(10, 1, "t2_enter");
        chk("t2_thr", 32'(cfg_thr), 32'd255);
        cycle(0, 0, 1, "t2_hs");

        // 3: saturation at both ends
        press(2, 1, "t3_k2");
        press(5, 1, "t3_k5");
        press(0, 1, "t3_k0");
        press(10, 1, "t3_enter");
        cycle(0, 0, 1, "t3_hs");
        press(13, 1, "t3_up");
        chk("t3_sat_hi", 32'(cfg_thr), 32'd255);
        cycle(0, 0, 1, "t3_hs2");
        for (int i = 0; i < 32; i++) begin
            press(14, 1, "t3_dn");
            cycle(0, 0, 1, "t3_dn_hs");
        end
        chk("t3_sat_lo", 32'(cfg_thr), 32'd0);

        // 4: pending configuration held while not ready
        press(12, 0, "t4_byp");
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, "t4_hold");
        chk("t4_vld_held", 32'(cfg_vld), 32'd1);
        chk("t4_byp", 32'(cfg_bypass), 32'd1);
        press(5, 0, "t4_k5");
        chk("t4_err", 32'(key_err), 32'd1);
        cycle(0, 0, 1, "t4_hs");
        chk("t4_idle", 32'(cfg_vld), 32'd0);

        // 5: cancel, then reset during commit
        press(4, 0, "t5_k4");
        press(11, 0, "t5_cancel");
        chk("t5_entry", 32'(entry_val), 32'd0);
        press(13, 0, "t5_up");
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t5_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, "t5_after_rst");

`ifdef ENTRY_TIMEOUT_EN
        // 6: open entry abandoned after TCYC idle cycles
        press(7, 0, "t6_k7");
        for (int i = 0; i < TCYC; i++) cycle(0, 0, 0, "t6_wait");
        chk("t6_err", 32'(key_err), 32'd1);
        chk("t6_busy", 32'(entry_busy), 32'd0);
        chk("t6_thr", 32'(cfg_thr), 32'(THR_DEF));
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 4) ? 1 : 0, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 1)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
